ccip_c1_wr_arbiter: RTL

- Shares the single CCI-P channel-1 TX port (memory writes, write fences, interrupts) among NUM_REQ AFU-side requesters.
- Arbitrates round-robin at packet granularity, so multi-CL writes (cl_len 2 or 4) go out as contiguous beats.
- Honours c1TxAlmFull and tags mdata with the requester ID.
- Routes channel-1 RX write responses back to the originating requester; sits between the AFU user logic and the CCI-P c1 Tx/Rx structures.

---
 rtl/ccip_c1_wr_arbiter_pkg.sv | 66 ++++++
 rtl/ccip_c1_wr_arbiter_if.sv | 24 ++
 rtl/ccip_rr_picker.sv | 27 ++
 rtl/ccip_c1_wr_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ccip_c1_wr_arbiter_pkg.sv
// CCI-P channel-1 types shared by the write arbiter, its requester interface
// and the round-robin picker.
package ccip_c1_wr_arbiter_pkg;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic {
        eARB_IDLE  = 1'b0,
        eARB_BURST = 1'b1
    } t_ccip_c1_arb_state;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    // Beats still owed after the sop beat of a multi-line write.
    function automatic logic [1:0] ccip_cl_len_beats_left(input t_ccip_clLen len);
        case (len)
            eCL_LEN_2: return 2'd1;
            eCL_LEN_4: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ccip_c1_wr_arbiter_if.sv
// Requester-side bundle of the channel-1 write arbiter: request beats in,
// ready and routed write responses out.
interface ccip_c1_wr_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import ccip_c1_wr_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                    req_valid;
    t_ccip_c1_ReqMemHdr [NUM_REQ-1:0]      req_hdr;
    logic [NUM_REQ-1:0][511:0]             req_data;
    logic [NUM_REQ-1:0]                    req_ready;
    logic [NUM_REQ-1:0]                    rsp_valid;
    t_ccip_c1_RspMemHdr                    rsp_hdr;

    modport master (
        output req_valid, req_hdr, req_data,
        input  req_ready, rsp_valid, rsp_hdr
    );

    modport slave (
        input  req_valid, req_hdr, req_data,
        output req_ready, rsp_valid, rsp_hdr
    );
endinterface

// File: rtl/ccip_rr_picker.sv
// Combinational round-robin find-first: lowest index at or after ptr_i
// (wrapping) whose request bit is set.
module ccip_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);
    logic hit_s;

    // Walk positions in priority order; the first hit wins and masks the rest.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                hit_s   = ~found_o & req_i[j] & (j == ((int'(ptr_i) + k) % N));
                idx_o   = hit_s ? IDX_W'(j) : idx_o;
                found_o = found_o | hit_s;
            end
        end
    end
endmodule

// File: rtl/ccip_c1_wr_arbiter.sv
// Shares the CCI-P c1 TX port among NUM_REQ requesters with packet-granular
// round-robin, tags mdata with the requester ID and routes responses back.
module ccip_c1_wr_arbiter
    import ccip_c1_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_LSB  = 14
) (
    input  logic                 pClk,
    input  logic                 pck_cp2af_softReset,
    ccip_c1_wr_arbiter_if.slave  req_if,
    input  logic                 c1TxAlmFull,
    output t_if_ccip_c1_Tx       c1Tx,
    input  t_if_ccip_c1_Rx       c1Rx,
    output logic                 err
);
    t_ccip_c1_arb_state state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic [1:0]         beats_left_q, beats_left_d, burst_len;
    logic [3:0]         stall_cnt_q, stall_cnt_d;
    logic               err_q, err_d;
    t_if_ccip_c1_Tx     c1tx_q, c1tx_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    t_ccip_c1_RspMemHdr rsp_hdr_q, rsp_hdr_d;

    logic [NUM_REQ-1:0] sop_vec, eligible, ready;
    logic               pick_found, owner_vld, grant_vld, stall_cond, rsp_bad;
    logic [1:0]         pick_idx, grant_idx, rsp_id;
    t_ccip_c1_ReqMemHdr grant_hdr;
    logic [511:0]       grant_data;

    function automatic logic [1:0] ptr_after(input logic [1:0] idx);
        return (32'(idx) >= NUM_REQ - 1) ? 2'd0 : idx + 2'd1;
    endfunction

    // Per-requester sop flags and whether the burst owner has a beat ready.
    always_comb begin
        sop_vec   = '0;
        owner_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sop_vec[i] = req_if.req_hdr[i].sop;
            owner_vld  = owner_vld | (req_if.req_valid[i] & (owner_q == 2'(i)));
        end
    end

    assign eligible = req_if.req_valid & sop_vec;

    ccip_rr_picker #(.N(NUM_REQ), .IDX_W(2)) u_picker (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // FSM state register.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            state_q      <= eARB_IDLE;
            rr_ptr_q     <= 2'd0;
            owner_q      <= 2'd0;
            beats_left_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
        end
    end

    // FSM next state: fences, interrupts and 1-CL writes never open a burst.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        burst_len    = ((grant_hdr.req_type == eREQ_WRLINE_I) || (grant_hdr.req_type == eREQ_WRLINE_M))
                     ? ccip_cl_len_beats_left(grant_hdr.cl_len) : 2'd0;
        case (state_q)
            eARB_IDLE: begin
                if (grant_vld && (burst_len != 2'd0)) begin
                    state_d      = eARB_BURST;
                    owner_d      = grant_idx;
                    beats_left_d = burst_len;
                end else if (grant_vld) begin
                    rr_ptr_d = ptr_after(grant_idx);
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
            end
            eARB_BURST: begin
                if (grant_vld) begin
                    beats_left_d = beats_left_q - 2'd1;
                    if (beats_left_q == 2'd1) begin
                        state_d  = eARB_IDLE;
                        rr_ptr_d = ptr_after(owner_q);
                    end else begin
                        state_d = eARB_BURST;
                    end
                end else begin
                    state_d = eARB_BURST;
                end
            end
            default: state_d = eARB_IDLE;
        endcase
    end

    // FSM outputs: grant selection; burst beats ignore AlmFull (at most 3 remain).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = owner_q;
        ready     = '0;
        case (state_q)
            eARB_IDLE: begin
                grant_vld = pick_found & ~c1TxAlmFull & ~pck_cp2af_softReset;
                grant_idx = pick_idx;
            end
            eARB_BURST: begin
                grant_vld = owner_vld & ~pck_cp2af_softReset;
                grant_idx = owner_q;
            end
            default: begin
                grant_vld = 1'b0;
                grant_idx = owner_q;
            end
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            ready[i] = grant_vld & (grant_idx == 2'(i));
        end
    end

    // Header/data mux for the granted requester.
    always_comb begin
        grant_hdr  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_hdr  = (grant_idx == 2'(i)) ? req_if.req_hdr[i]  : grant_hdr;
            grant_data = (grant_idx == 2'(i)) ? req_if.req_data[i] : grant_data;
        end
    end

    // Datapath next state: TX stage, response routing, error detection.
    always_comb begin
        c1tx_d       = c1tx_q;
        c1tx_d.valid = grant_vld;
        if (grant_vld) begin
            c1tx_d.hdr                     = grant_hdr;
            c1tx_d.hdr.mdata[ID_LSB +: 2]  = grant_idx;
            c1tx_d.data                    = grant_data;
        end else begin
            c1tx_d.hdr  = c1tx_q.hdr;
            c1tx_d.data = c1tx_q.data;
        end

        rsp_id      = c1Rx.hdr.mdata[ID_LSB +: 2];
        rsp_bad     = c1Rx.rspValid & ~(32'(rsp_id) < 32'(NUM_REQ));
        rsp_valid_d = '0;
        rsp_hdr_d   = rsp_hdr_q;
        if (c1Rx.rspValid && !rsp_bad) begin
            rsp_hdr_d                    = c1Rx.hdr;
            rsp_hdr_d.mdata[ID_LSB +: 2] = 2'b00;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (rsp_id == 2'(i));
            end
        end else begin
            rsp_hdr_d = rsp_hdr_q;
        end

        // A lone valid requester with no sop can never be granted: count it.
        stall_cond  = (state_q == eARB_IDLE) & $onehot(req_if.req_valid) & ~(|eligible);
        stall_cnt_d = stall_cond ? ((stall_cnt_q == 4'hF) ? 4'hF : stall_cnt_q + 4'd1) : 4'd0;

        err_d = err_q
              | ((state_q == eARB_BURST) & grant_vld & grant_hdr.sop)
              | (stall_cond & (stall_cnt_q == 4'hF))
              | rsp_bad;
    end

    // Datapath registers.
    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            c1tx_q      <= '0;
            rsp_valid_q <= '0;
            rsp_hdr_q   <= '0;
            stall_cnt_q <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            c1tx_q      <= c1tx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hdr_q   <= rsp_hdr_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign c1Tx             = c1tx_q;
    assign err              = err_q;
    assign req_if.req_ready = ready;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_hdr   = rsp_hdr_q;

endmodule
